// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting window, one pixel per cycle.
// Define SOBEL_PRESCALE_EN to right-shift every pixel by 2 before it is stored.
module sobel_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic [DATA_W-1:0]   in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9*DATA_W-1:0] out_win,
    output logic [6:0]          out_row,
    output logic [6:0]          out_col,
    output logic                frame_done
);
    localparam int         AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [6:0] COL_LAST = 7'(IMG_W - 1);
    localparam logic [6:0] ROW_LAST = 7'(IMG_H - 1);

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    logic [6:0]        row, col;
    logic [6:0]        cur_row, cur_col;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] pix, top, mid;
    logic              accept, emit, last_pixel;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign cur_row    = in_sof ? 7'd0 : row;
    assign cur_col    = in_sof ? 7'd0 : col;
    assign addr       = cur_col[AW-1:0];
    assign emit       = (cur_row >= 7'd2) && (cur_col >= 7'd2);
    assign last_pixel = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

`ifdef SOBEL_PRESCALE_EN
    assign pix = in_pixel >> 2;
`else
    assign pix = in_pixel;
`endif

    assign top = lb1[addr];
    assign mid = lb0[addr];

    // NOTE: line buffers carry no reset; every entry is rewritten before it can reach a window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= pix;
        end
    end

    // NOTE: all state below uses <= so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            out_valid  <= 1'b0;
            out_win    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                // out_win doubles as the window register; it only moves on acceptance,
                // which cannot happen while the output slot is stalled.
                for (int i = 0; i < 3; i++) begin
                    out_win[(3*i)*DATA_W +: DATA_W]   <= out_win[(3*i+1)*DATA_W +: DATA_W];
                    out_win[(3*i+1)*DATA_W +: DATA_W] <= out_win[(3*i+2)*DATA_W +: DATA_W];
                end
                out_win[2*DATA_W +: DATA_W] <= top;
                out_win[5*DATA_W +: DATA_W] <= mid;
                out_win[8*DATA_W +: DATA_W] <= pix;

                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? 7'd0 : cur_row + 7'd1;
                end else begin
                    col <= cur_col + 7'd1;
                    row <= cur_row;
                end

                out_valid <= emit;
                if (emit) begin
                    out_row <= cur_row - 7'd1;
                    out_col <= cur_col - 7'd1;
                end
                frame_done <= last_pixel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized bench for sobel_window_gen: a frame-array model predicts every window and handshake.
// Honours SOBEL_PRESCALE_EN the same way the design does.
module tb_sobel_window_gen;
    localparam int DW = 8;
    localparam int W  = 64;
    localparam int H  = 64;
    localparam int NPIX = W * H;

    localparam int MODE_RAMP  = 0;
    localparam int MODE_RAND  = 1;
    localparam int MODE_CONST = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sof = 1'b0;
    logic [DW-1:0]   in_pixel = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [9*DW-1:0] out_win;
    logic [6:0]      out_row, out_col;
    logic            frame_done;

    sobel_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
        .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pre(input logic [DW-1:0] p);
`ifdef SOBEL_PRESCALE_EN
        return p >> 2;
`else
        return p;
`endif
    endfunction

    // Model: the frame as stored pixels plus the single expected output slot.
    logic [DW-1:0]   img [0:H-1][0:W-1];
    int              idx = 0;
    bit              exp_valid = 1'b0;
    bit              exp_done = 1'b0;
    logic [9*DW-1:0] exp_win = '0;
    logic [6:0]      exp_row = '0, exp_col = '0;
    int              model_win_cnt = 0;

    // Observations taken from the DUT, compared against literals after each test.
    int              dut_win_cnt = 0;
    int              done_cnt = 0;
    bit              first_seen = 1'b0;
    logic [9*DW-1:0] first_win;
    logic [6:0]      first_row, first_col, last_row, last_col;

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, exp_valid);
            check("frame_done", frame_done, exp_done);
            if (exp_valid) begin
                check("out_win", out_win, exp_win);
                check("out_row", out_row, exp_row);
                check("out_col", out_col, exp_col);
            end
            if (frame_done) done_cnt++;
            if (out_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_win  = out_win;
                    first_row  = out_row;
                    first_col  = out_col;
                end
                last_row = out_row;
                last_col = out_col;
            end
        end
    end

    task automatic clear_obs();
        dut_win_cnt   = 0;
        done_cnt      = 0;
        first_seen    = 1'b0;
        model_win_cnt = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, predict the next state, wait for the rise.
    task automatic step(input bit v, input bit sof, input logic [DW-1:0] pix,
                        input bit ordy, output bit acc);
        int r, c;
        @(negedge clk);
        in_valid  = v;
        in_sof    = sof;
        in_pixel  = pix;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !exp_valid || ordy);
        if (out_valid && ordy) dut_win_cnt++;
        acc = v && (!exp_valid || ordy);
        exp_done = 1'b0;
        if (acc) begin
            if (sof) idx = 0;
            r = idx / W;
            c = idx % W;
            img[r][c] = pre(pix);
            if (r >= 2 && c >= 2) begin
                exp_valid = 1'b1;
                for (int k = 0; k < 9; k++)
                    exp_win[k*DW +: DW] = img[r-2+k/3][c-2+k%3];
                exp_row = 7'(r - 1);
                exp_col = 7'(c - 1);
                model_win_cnt++;
            end else begin
                exp_valid = 1'b0;
            end
            exp_done = (idx == NPIX - 1);
            idx = (idx + 1) % NPIX;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic send_pixel(input bit sof, input logic [DW-1:0] pix, input bit rnd_rdy);
        bit acc;
        for (int n = 0; n < 200; n++) begin
            step(1'b1, sof, pix, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            if (acc) return;
        end
        failures++;
        $display("FAIL send_pixel: pixel not accepted within 200 cycles");
    endtask

    task automatic run_frame(input int mode, input int npix, input int gap,
                             input bit rnd_rdy, input bit first_sof, input bit drain);
        bit acc;
        logic [DW-1:0] p;
        for (int i = 0; i < npix; i++) begin
            case (mode)
                MODE_RAMP: p = DW'(((i / W) * 64 + (i % W)) % 256);
                MODE_RAND: p = DW'($urandom);
                default:   p = 8'hFF;
            endcase
            send_pixel(first_sof && i == 0, p, rnd_rdy);
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'b0, '0, rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1, acc);
        end
        if (drain)
            for (int d = 0; d < 4; d++) step(1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_win", out_win, '0);
        check("rst out_row", out_row, '0);
        check("rst out_col", out_col, '0);
        check("rst frame_done", frame_done, 1'b0);
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        idx       = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_full_frame(input string tag);
        check({tag, " dut windows"}, dut_win_cnt, 3844);
        check({tag, " model windows"}, model_win_cnt, 3844);
        check({tag, " frame_done pulses"}, done_cnt, 1);
        check({tag, " last out_row"}, last_row, 7'd62);
        check({tag, " last out_col"}, last_col, 7'd62);
    endtask

    logic [DW-1:0] const_exp;

    initial begin
        do_reset();

        // Ramp frame, no stalls: pin first window against hand-computed values.
        clear_obs();
        run_frame(MODE_RAMP, NPIX, 0, 1'b0, 1'b1, 1'b1);
        check_full_frame("ramp");
        check("ramp first row", first_row, 7'd1);
        check("ramp first col", first_col, 7'd1);
        check("ramp first P0", first_win[0*DW +: DW], pre(8'd0));
        check("ramp first P4", first_win[4*DW +: DW], pre(8'd65));
        check("ramp first P8", first_win[8*DW +: DW], pre(8'd130));

        // Same frame with random backpressure.
        clear_obs();
        run_frame(MODE_RAMP, NPIX, 0, 1'b1, 1'b1, 1'b1);
        check_full_frame("stall");

        // One pixel every three cycles.
        clear_obs();
        run_frame(MODE_RAMP, NPIX, 2, 1'b0, 1'b1, 1'b1);
        check_full_frame("gap");

        // Random pixels with random backpressure and random gaps.
        clear_obs();
        run_frame(MODE_RAND, NPIX, $urandom_range(0, 1), 1'b1, 1'b1, 1'b1);
        check_full_frame("random");

        // Frame abandoned at (10,5) by a new start of frame.
        clear_obs();
        run_frame(MODE_RAND, 10 * W + 5, 0, 1'b0, 1'b1, 1'b1);
        check("sof abandoned frame_done", done_cnt, 0);
        clear_obs();
        run_frame(MODE_RAND, NPIX, 0, 1'b0, 1'b1, 1'b1);
        check_full_frame("sof");
        check("sof first row", first_row, 7'd1);
        check("sof first col", first_col, 7'd1);

        // Reset at (30,30) while a window is pending, then a frame with no in_sof.
        run_frame(MODE_RAMP, 30 * W + 30, 0, 1'b0, 1'b1, 1'b0);
        do_reset();
        clear_obs();
        run_frame(MODE_RAMP, NPIX, 0, 1'b0, 1'b0, 1'b1);
        check_full_frame("post-reset");

        // Constant 0xFF frame exercises the prescale option.
`ifdef SOBEL_PRESCALE_EN
        const_exp = 8'h3F;
`else
        const_exp = 8'hFF;
`endif
        clear_obs();
        run_frame(MODE_CONST, NPIX, 0, 1'b0, 1'b1, 1'b1);
        check_full_frame("const");
        check("const first window", first_win, {9{const_exp}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
